run_detect_ctrl: RTL and testbench

//   Armable run-length monitor controller for serial bit stream w.

---
 rtl/run_detect_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_run_detect_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl -- armable run-length monitor for the serial stream w.
//
// A host arms the block with a non-zero run threshold. While tracking, z is
// high whenever the current run of identical bits is at or above that
// threshold. Each time a run reaches the threshold an event is counted. On
// stop, the event count and the value of the final run are offered once over
// a valid/ready handshake.
//
// Optional feature (macro RUN_DETECT_CTRL_OVF_EN):
//   adds output evt_ovf. It is a sticky flag, set when an event arrives while
//   the event counter is already saturated. It is cleared by the next accepted
//   start or by reset, and it is held alongside the report.
//
// Parameters
//   RUN_W  width of threshold and run counter (run counter saturates)
//   EVT_W  width of the event counter / rpt_count (saturates)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         arm request (honoured in IDLE only, ignored when thresh==0)
//   stop          end of monitoring (honoured in ARM/TRACK only)
//   thresh        run threshold, captured on an accepted start
//   w             serial data, sampled every clock in ARM/TRACK
//   z             registered: current run length >= captured threshold
//   busy          high in ARM, TRACK and REPORT
//   rpt_valid     report available
//   rpt_ready     host accepts the report
//   rpt_count     events counted during the session
//   rpt_last_val  bit value of the final run
//   evt_ovf       (optional) sticky event-counter overflow flag

module run_detect_ctrl #(
   parameter int unsigned RUN_W = 4,
   parameter int unsigned EVT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [RUN_W-1:0] thresh,
   input  logic             w,
   output logic             z,
   output logic             busy,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [EVT_W-1:0] rpt_count,
   output logic             rpt_last_val
`ifdef RUN_DETECT_CTRL_OVF_EN
   ,
   output logic             evt_ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      TRACK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [EVT_W-1:0] EVT_MAX = '1;
   localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

   state_t           state_q, state_d;
   logic             z_q, z_d;
   logic             busy_q, busy_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [EVT_W-1:0] rpt_count_q, rpt_count_d;
   logic             rpt_last_q, rpt_last_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
   logic             last_w_q, last_w_d;
   logic [RUN_W-1:0] thr_q, thr_d;
`ifdef RUN_DETECT_CTRL_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [RUN_W-1:0] run_next;
   logic             hit;

   always_comb begin
      state_d     = state_q;
      z_d         = z_q;
      busy_d      = busy_q;
      rpt_valid_d = rpt_valid_q;
      rpt_count_d = rpt_count_q;
      rpt_last_d  = rpt_last_q;
      run_cnt_d   = run_cnt_q;
      evt_cnt_d   = evt_cnt_q;
      last_w_d    = last_w_q;
      thr_d       = thr_q;
`ifdef RUN_DETECT_CTRL_OVF_EN
      ovf_d       = ovf_q;
`endif
      run_next    = '0;
      hit         = 1'b0;

      case (state_q)
         IDLE: begin
            // start outranks a simultaneous stop; a zero threshold is never armed
            if (start && (thresh != '0)) begin
               thr_d     = thresh;
               evt_cnt_d = '0;
`ifdef RUN_DETECT_CTRL_OVF_EN
               ovf_d     = 1'b0;
`endif
               busy_d    = 1'b1;
               state_d   = ARM;
            end
         end

         ARM: begin
            if (stop) begin
               z_d         = 1'b0;
               rpt_valid_d = 1'b1;
               rpt_count_d = evt_cnt_q;
               rpt_last_d  = last_w_q;
               state_d     = REPORT;
            end else begin
               // first sample always opens a run of length one
               last_w_d  = w;
               run_cnt_d = RUN_ONE;
               z_d       = (thr_q == RUN_ONE);
               hit       = (thr_q == RUN_ONE);
               state_d   = TRACK;
            end
         end

         TRACK: begin
            if (stop) begin
               z_d         = 1'b0;
               rpt_valid_d = 1'b1;
               rpt_count_d = evt_cnt_q;
               rpt_last_d  = last_w_q;
               state_d     = REPORT;
            end else begin
               if (w == last_w_q) begin
                  run_next = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + RUN_ONE;
               end else begin
                  run_next = RUN_ONE;
               end
               run_cnt_d = run_next;
               last_w_d  = w;
               z_d       = (run_next >= thr_q);
               // An event is the moment a run reaches the threshold. A run that
               // merely continues at the threshold (saturated counter included)
               // does not count again; a fresh run always may.
               hit       = (run_next == thr_q) &&
                           !((w == last_w_q) && (run_cnt_q == thr_q));
            end
         end

         REPORT: begin
            if (rpt_ready) begin
               rpt_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (hit) begin
         if (evt_cnt_q != EVT_MAX) begin
            evt_cnt_d = evt_cnt_q + EVT_ONE;
         end
`ifdef RUN_DETECT_CTRL_OVF_EN
         else begin
            ovf_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         z_q         <= 1'b0;
         busy_q      <= 1'b0;
         rpt_valid_q <= 1'b0;
         rpt_count_q <= '0;
         rpt_last_q  <= 1'b0;
         run_cnt_q   <= '0;
         evt_cnt_q   <= '0;
         last_w_q    <= 1'b0;
         thr_q       <= '0;
`ifdef RUN_DETECT_CTRL_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
         busy_q      <= busy_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_count_q <= rpt_count_d;
         rpt_last_q  <= rpt_last_d;
         run_cnt_q   <= run_cnt_d;
         evt_cnt_q   <= evt_cnt_d;
         last_w_q    <= last_w_d;
         thr_q       <= thr_d;
`ifdef RUN_DETECT_CTRL_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign z            = z_q;
   assign busy         = busy_q;
   assign rpt_valid    = rpt_valid_q;
   assign rpt_count    = rpt_count_q;
   assign rpt_last_val = rpt_last_q;
`ifdef RUN_DETECT_CTRL_OVF_EN
   assign evt_ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Testbench for run_detect_ctrl. Directed stimulus pushes expected values
// into two scoreboard queues: timed signal checks and expected reports. A
// separate monitor pops and compares them. EVT_W is kept small so the event
// counter saturates within a short session.

module tb_run_detect_ctrl;

   localparam int unsigned RUN_W = 4;
   localparam int unsigned EVT_W = 2;

   localparam int S_Z     = 0;
   localparam int S_BUSY  = 1;
   localparam int S_VALID = 2;
   localparam int S_CNT   = 3;
   localparam int S_LAST  = 4;
   localparam int S_OVF   = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic [RUN_W-1:0] thresh;
   logic             w;
   logic             z;
   logic             busy;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [EVT_W-1:0] rpt_count;
   logic             rpt_last_val;
`ifdef RUN_DETECT_CTRL_OVF_EN
   logic             evt_ovf;
`endif

   run_detect_ctrl #(
      .RUN_W(RUN_W),
      .EVT_W(EVT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .thresh       (thresh),
      .w            (w),
      .z            (z),
      .busy         (busy),
      .rpt_valid    (rpt_valid),
      .rpt_ready    (rpt_ready),
      .rpt_count    (rpt_count),
      .rpt_last_val (rpt_last_val)
`ifdef RUN_DETECT_CTRL_OVF_EN
      ,
      .evt_ovf      (evt_ovf)
`endif
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   typedef struct {
      int    cyc;
      string name;
      int    sel;
      int    val;
   } chk_t;

   typedef struct {
      int cnt;
      int last;
      bit use_last;
   } rpt_t;

   chk_t chk_q[$];
   rpt_t rpt_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic int act(int sel);
      case (sel)
         S_Z:     return int'(z);
         S_BUSY:  return int'(busy);
         S_VALID: return int'(rpt_valid);
         S_CNT:   return int'(rpt_count);
         S_LAST:  return int'(rpt_last_val);
`ifdef RUN_DETECT_CTRL_OVF_EN
         S_OVF:   return int'(evt_ovf);
`endif
         default: return -1;
      endcase
   endfunction

   task automatic check(input string nm, input int got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, edges, got, want);
      end
   endtask

   // Monitor: timed checks fire at their cycle; reports are compared on every
   // cycle rpt_valid is high and retired on the handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < chk_q.size(); ) begin
            if (chk_q[i].cyc <= edges) begin
               check(chk_q[i].name, act(chk_q[i].sel), chk_q[i].val);
               chk_q.delete(i);
            end else begin
               i++;
            end
         end
         if (rpt_valid === 1'b1) begin
            if (rpt_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rpt_unexpected @edge %0d: got rpt_valid=1, expected no report", edges);
            end else begin
               check("rpt_count", int'(rpt_count), rpt_q[0].cnt);
               if (rpt_q[0].use_last) check("rpt_last_val", int'(rpt_last_val), rpt_q[0].last);
               if (rpt_ready === 1'b1) void'(rpt_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_at(input string nm, input int sel, input int val, input int d);
      chk_q.push_back('{edges + d, nm, sel, val});
   endtask

   task automatic expect_all_zero(input string tag);
      expect_at({tag, "_z"},     S_Z,     0, 0);
      expect_at({tag, "_busy"},  S_BUSY,  0, 0);
      expect_at({tag, "_valid"}, S_VALID, 0, 0);
      expect_at({tag, "_cnt"},   S_CNT,   0, 0);
      expect_at({tag, "_last"},  S_LAST,  0, 0);
`ifdef RUN_DETECT_CTRL_OVF_EN
      expect_at({tag, "_ovf"},   S_OVF,   0, 0);
`endif
   endtask

   task automatic arm(input int th);
      start  = 1'b1;
      thresh = RUN_W'(th);
      tick();
      start  = 1'b0;
      expect_at("busy_arm", S_BUSY, 1, 0);
   endtask

   task automatic feed(input logic b, input int ez);
      w = b;
      expect_at("z", S_Z, ez, 1);
      tick();
   endtask

   // stop, optionally hold rpt_ready low for some cycles, then accept
   task automatic close(input int cnt, input int last, input bit use_last, input int hold);
      stop = 1'b1;
      rpt_q.push_back('{cnt, last, use_last});
      expect_at("z_stop", S_Z, 0, 1);
      tick();
      stop = 1'b0;
      expect_at("valid_up", S_VALID, 1, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         expect_at("valid_hold", S_VALID, 1, 0);
         expect_at("busy_hold",  S_BUSY,  1, 0);
      end
      rpt_ready = 1'b1;
      expect_at("valid_drop", S_VALID, 0, 1);
      expect_at("busy_drop",  S_BUSY,  0, 1);
      tick();
      rpt_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; thresh = '0; w = 1'b0; rpt_ready = 1'b0;
      tick();
      tick();
      expect_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // T1: threshold 5, seven zeros
      arm(5);
      for (int i = 0; i < 7; i++) feed(1'b0, (i >= 4) ? 1 : 0);
      close(1, 0, 1, 0);

      // T2 + T5: threshold 3, mixed runs, report held for 4 cycles
      arm(3);
      feed(1'b1, 0); feed(1'b1, 0); feed(1'b1, 1); feed(1'b0, 0);
      feed(1'b0, 0); feed(1'b0, 1); feed(1'b0, 1); feed(1'b1, 0);
      close(2, 1, 1, 4);

      // T3: zero threshold ignored, stop in IDLE ignored
      start = 1'b1; thresh = '0;
      tick();
      start = 1'b0;
      expect_at("busy_thr0", S_BUSY, 0, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      expect_at("busy_idle_stop",  S_BUSY,  0, 0);
      expect_at("valid_idle_stop", S_VALID, 0, 0);
      // start and stop together in IDLE: start wins
      start = 1'b1; stop = 1'b1; thresh = RUN_W'(3);
      tick();
      start = 1'b0; stop = 1'b0;
      expect_at("busy_start_wins", S_BUSY, 1, 0);
      feed(1'b1, 0);
      // re-start with threshold 1 while tracking must not take effect
      start = 1'b1; thresh = RUN_W'(1);
      feed(1'b1, 0);
      feed(1'b1, 1);
      start = 1'b0;
      close(1, 1, 1, 0);

      // stop while in ARM: empty report
      arm(4);
      close(0, 0, 0, 0);

      // T4: threshold 15, twenty ones, run counter saturates
      arm(15);
      for (int i = 0; i < 20; i++) feed(1'b1, (i >= 14) ? 1 : 0);
      close(1, 1, 1, 0);

      // Event counter saturation (EVT_W=2): four events report 3
      arm(2);
      feed(1'b0, 0); feed(1'b0, 1); feed(1'b1, 0); feed(1'b1, 1);
      feed(1'b0, 0); feed(1'b0, 1);
`ifdef RUN_DETECT_CTRL_OVF_EN
      expect_at("ovf_before", S_OVF, 0, 0);
`endif
      feed(1'b1, 0); feed(1'b1, 1);
`ifdef RUN_DETECT_CTRL_OVF_EN
      expect_at("ovf_set", S_OVF, 1, 0);
      expect_at("ovf_in_report", S_OVF, 1, 1);
`endif
      close(3, 1, 1, 0);
`ifdef RUN_DETECT_CTRL_OVF_EN
      expect_at("ovf_sticky_idle", S_OVF, 1, 0);
      arm(3);
      expect_at("ovf_cleared", S_OVF, 0, 0);
      close(0, 0, 0, 0);
`endif

      // T6a: reset while tracking with z high
      arm(2);
      feed(1'b1, 0);
      feed(1'b1, 1);
      expect_at("busy_pre_rst", S_BUSY, 1, 0);
      rst_n = 1'b0;
      tick();
      expect_all_zero("rst_track");
      rst_n = 1'b1;

      // T6b: reset while a report is pending
      arm(1);
      feed(1'b1, 1);
      stop = 1'b1;
      rpt_q.push_back('{1, 1, 1'b1});
      tick();
      stop = 1'b0;
      expect_at("valid_pre_rst", S_VALID, 1, 0);
      rst_n = 1'b0;
      tick();
      rpt_q.delete();
      expect_all_zero("rst_report");
      rst_n = 1'b1;
      tick();
      expect_at("idle_after_rst", S_BUSY, 0, 0);
      tick();
      tick();

      if (chk_q.size() != 0 || rpt_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: got %0d checks/%0d reports pending, expected 0/0",
                  chk_q.size(), rpt_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
